// File: rtl/beat_sequencer.sv
// beat_sequencer
// ----------------------------------------------------------------------------
// Machine-cycle sequencer for the main control unit. It produces the fetch
// (W1) and execute (W2) beats and the four timing pulses T1..T4 within a
// beat. It also captures the instruction register on CPIR and keeps a
// registered one-hot decode of the opcode field.
//
// The execute beat length depends on the latched opcode:
//   MOV1 and MOV2 end at T3, MOV3 ends at T4, and every other opcode
//   (including illegal ones) ends at T1.
// A G strobe while running stops the machine on the next edge. STEP=1 stops
// it at the end of each instruction.
//
// Ports
//   CLK      system clock, rising edge
//   CLRN     synchronous reset, active-low
//   START    run request; honoured only while stopped
//   STEP     single-step mode level, sampled at the last execute T
//   IR       instruction bus; opcode field is IR[OP_LSB+4:OP_LSB]
//   CPIR     IR load strobe
//   G        halt strobe
//   T1..T4   one-hot timing pulses
//   W1, W2   fetch / execute beat
//   P        running qualifier (W1|W2)
//   STOPPED  machine idle
//   MOV1..HALT, ILL  registered one-hot opcode decode
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module beat_sequencer #(
    parameter int IR_W   = 8,
    parameter int OP_LSB = 3
) (
    input  logic            CLK,
    input  logic            CLRN,
    input  logic            START,
    input  logic            STEP,
    input  logic [IR_W-1:0] IR,
    input  logic            CPIR,
    input  logic            G,
    output logic            T1,
    output logic            T2,
    output logic            T3,
    output logic            T4,
    output logic            W1,
    output logic            W2,
    output logic            P,
    output logic            STOPPED,
    output logic            MOV1,
    output logic            MOV2,
    output logic            MOV3,
    output logic            ADD,
    output logic            SUB,
    output logic            MUL,
    output logic            DIV,
    output logic            SHIFT,
    output logic            AND,
    output logic            OR,
    output logic            XOR,
    output logic            AN,
    output logic            A1,
    output logic            AB1,
    output logic            OA,
    output logic            OB,
    output logic            HALT,
    output logic            ILL
);

    // One-hot state encoding, so the W1/W2/STOPPED outputs are plain flop bits.
    typedef enum logic [2:0] {
        ST_STOP  = 3'b001,
        ST_FETCH = 3'b010,
        ST_EXEC  = 3'b100
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [1:0]      t_idx_r;     // 0..3 stands for T1..T4
    logic [1:0]      t_idx_s;
    logic [3:0]      t_oh_r;      // bit 0 = T1
    logic [3:0]      t_oh_s;
    logic            p_r;
    logic            p_s;
    logic [IR_W-1:0] ir_r;
    logic [17:0]     dec_r;       // bits 0..16 = ops, bit 17 = ILL
    logic [4:0]      op_s;
    logic [4:0]      op_in_s;
    logic [1:0]      last_idx_s;
    logic            unused_ir_s;

    // Decodes a 5-bit opcode field into the 17 op lines plus ILL.
    function automatic logic [17:0] decode_op(input logic [4:0] op);
        logic [17:0] d;
        d = 18'd0;
        if (op <= 5'd16) begin
            d[op] = 1'b1;
        end else begin
            d[17] = 1'b1;
        end
        return d;
    endfunction

    assign op_s        = ir_r[OP_LSB+4:OP_LSB];
    assign op_in_s     = IR[OP_LSB+4:OP_LSB];
    assign unused_ir_s = ^ir_r;

    // Last T index of the execute beat, taken from the latched opcode.
    always_comb begin
        last_idx_s = 2'd0;
        case (op_s)
            5'd0, 5'd1: last_idx_s = 2'd2;
            5'd2:       last_idx_s = 2'd3;
            default:    last_idx_s = 2'd0;
        endcase
    end

    // Next beat / T selection and the next registered pulse values.
    always_comb begin
        state_s = state_r;
        t_idx_s = t_idx_r;
        t_oh_s  = 4'b0000;
        p_s     = 1'b0;
        case (state_r)
            ST_STOP: begin
                t_idx_s = 2'd0;
                if (START) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_STOP;
                end
            end
            ST_FETCH: begin
                if (G) begin
                    state_s = ST_STOP;
                    t_idx_s = 2'd0;
                end else if (t_idx_r >= 2'd2) begin
                    state_s = ST_EXEC;
                    t_idx_s = 2'd0;
                end else begin
                    t_idx_s = t_idx_r + 2'd1;
                end
            end
            ST_EXEC: begin
                // ">=" rather than "==": a CPIR reload mid-execute can
                // shorten the beat, and the beat must still terminate.
                if (G) begin
                    state_s = ST_STOP;
                    t_idx_s = 2'd0;
                end else if (t_idx_r >= last_idx_s) begin
                    t_idx_s = 2'd0;
                    if (STEP) begin
                        state_s = ST_STOP;
                    end else begin
                        state_s = ST_FETCH;
                    end
                end else begin
                    t_idx_s = t_idx_r + 2'd1;
                end
            end
            default: begin
                state_s = ST_STOP;
                t_idx_s = 2'd0;
            end
        endcase
        if (state_s == ST_STOP) begin
            t_oh_s = 4'b0000;
            p_s    = 1'b0;
        end else begin
            t_oh_s = 4'b0001 << t_idx_s;
            p_s    = 1'b1;
        end
    end

    // Sequencer state and the registered beat/pulse outputs.
    always_ff @(posedge CLK) begin
        if (!CLRN) begin
            state_r <= ST_STOP;
            t_idx_r <= 2'd0;
            t_oh_r  <= 4'b0000;
            p_r     <= 1'b0;
        end else begin
            state_r <= state_s;
            t_idx_r <= t_idx_s;
            t_oh_r  <= t_oh_s;
            p_r     <= p_s;
        end
    end

    // Instruction register and its decode. Decoding the incoming bus gives
    // valid lines one cycle after the CPIR edge.
    always_ff @(posedge CLK) begin
        if (!CLRN) begin
            ir_r  <= '0;
            dec_r <= 18'd0;
        end else if (CPIR) begin
            ir_r  <= IR;
            dec_r <= decode_op(op_in_s);
        end else begin
            ir_r  <= ir_r;
            dec_r <= dec_r;
        end
    end

    assign T1      = t_oh_r[0];
    assign T2      = t_oh_r[1];
    assign T3      = t_oh_r[2];
    assign T4      = t_oh_r[3];
    assign W1      = state_r[1];
    assign W2      = state_r[2];
    assign STOPPED = state_r[0];
    assign P       = p_r;

    assign MOV1  = dec_r[0];
    assign MOV2  = dec_r[1];
    assign MOV3  = dec_r[2];
    assign ADD   = dec_r[3];
    assign SUB   = dec_r[4];
    assign MUL   = dec_r[5];
    assign DIV   = dec_r[6];
    assign SHIFT = dec_r[7];
    assign AND   = dec_r[8];
    assign OR    = dec_r[9];
    assign XOR   = dec_r[10];
    assign AN    = dec_r[11];
    assign A1    = dec_r[12];
    assign AB1   = dec_r[13];
    assign OA    = dec_r[14];
    assign OB    = dec_r[15];
    assign HALT  = dec_r[16];
    assign ILL   = dec_r[17];

endmodule
